tipi_sreg_bank: RTL and testbench
=================================

Name: tipi_sreg_bank

Overview:
- Parametrised successor to the fixed TD/TC/RD/RC register quartet between the TI-99/4A bus and the Raspberry Pi serial link.
- Provides CHANNELS register pairs of WIDTH bits. Each pair has one TI->RPi register and one RPi->TI register.
- All asynchronous inputs (RPi r_clk/r_le, TI write strobe) are synchronised into a single system clock.
- Adds two features the fixed design lacks: a per-channel bit-count check that rejects short or long RPi transfers, and per-channel "new data" flags for both directions.

Parameters:
- WIDTH, 8, bits per register.
- CHANNELS, 2, number of register pairs (channel 0 = control, channel 1 = data).
- CH_W, 1, width of channel selects; must equal clog2(CHANNELS), minimum 1.
- SYNC_STAGES, 2, flop depth of each input synchroniser; minimum 2.

Ports:
- clk, input, 1: system clock, all state on its rising edge.
- reset, input, 1: synchronous, active-high.
- ti_wr, input, 1: async TI write strobe (decoded ~we & ~memen & address match); active high.
- ti_wsel, input, CH_W: TI write channel select; sampled with ti_wr.
- ti_wdata, input, WIDTH: TI write data; sampled with ti_wr.
- ti_rsel, input, CH_W: TI read channel select.
- ti_rdir, input, 1: 0 = read the RPi->TI register, 1 = read back the TI->RPi register.
- ti_rdata, output, WIDTH: combinational read mux of the selected register.
- ti_rack, input, 1: 1-cycle pulse; TI has consumed the RPi->TI register selected by ti_rsel.
- r_clk, input, 1: async RPi shift clock.
- r_le, input, 1: async RPi latch enable.
- r_rt, input, 1: 0 = RPi writes (shift in), 1 = RPi reads (shift out).
- r_ch, input, CH_W: RPi channel select.
- r_dout, input, 1: serial data from RPi.
- r_din, output, 1: serial data to RPi.
- tx_new, output, CHANNELS: TI->RPi register written, not yet fetched by RPi.
- rx_new, output, CHANNELS: RPi->TI register updated, not yet acked by TI.
- rx_err, output, CHANNELS: sticky; last RPi write had a bit count != WIDTH.

Behaviour:
- Reset: all registers, shifters and counters = 0; tx_new = rx_new = rx_err = 0; r_din = 0; synchroniser chains = 0, so no edge is detected on the first cycle after reset.
- Synchronisers: r_clk, r_le and ti_wr each pass through SYNC_STAGES flops. A rising edge is detected as sync = 1 and previous = 0, producing a 1-cycle event. r_rt, r_ch and r_dout are sampled on the cycle the r_clk event fires; they are stable because the RPi changes them only on the falling edge of r_clk.
- TI write (ti_wr event, latency SYNC_STAGES+1 from the async rise):
  - tx_reg[ti_wsel] <= ti_wdata; tx_new[ti_wsel] <= 1.
  - ti_wdata and ti_wsel must be held for the whole strobe.
- RPi read (r_rt = 1):
  - On an r_le event, shift_out <= tx_reg[r_ch], r_din <= MSB of that value, and tx_new[r_ch] <= 0.
  - On each r_clk event, shift left and r_din <= next bit. After WIDTH shifts r_din = 0.
- RPi write (r_rt = 0):
  - On each r_clk event, shift_in <= {shift_in[WIDTH-2:0], r_dout}, and bitcnt increments, saturating at WIDTH+1.
  - On an r_le event:
    - If bitcnt == WIDTH: rx_reg[r_ch] <= shift_in, rx_new[r_ch] <= 1, rx_err[r_ch] <= 0.
    - Otherwise: rx_reg is unchanged and rx_err[r_ch] <= 1.
    - In both cases bitcnt <= 0.
- ti_rack: rx_new[ti_rsel] <= 0.
- Simultaneous events:
  - An r_le event and an r_clk event in the same cycle: r_le is processed using the pre-shift state, and the r_clk event is dropped.
  - ti_rack and an rx_new set on the same channel in the same cycle: set wins.
  - A TI write and an RPi fetch of the same tx channel in the same cycle: the RPi fetch loads the old value, and tx_new ends at 1.
- State machine for the RPi link: IDLE -> SHIFT on the first r_clk event; SHIFT -> IDLE on an r_le event. A change of r_rt or r_ch while in SHIFT: bitcnt <= 0 and the link returns to IDLE. For a write, the subsequent r_le therefore sets rx_err.
- Reset mid-transfer: the partial shift is discarded with no flag set, and registers return to 0.

Decomposition:
- Package tipi_pkg holds the RT_READ/RT_WRITE constants, the link state enum (IDLE, SHIFT), and a clog2 function.
- Sub-module tipi_sync_edge (parametrised SYNC_STAGES; outputs sync level and rise pulse) is instantiated three times.

Test Plan:
- Reset then idle 10 clocks -> tx_new = rx_new = rx_err = 0, r_din = 0, ti_rdata = 0 for every channel and direction.
- TI writes 0xA5 to ch1; RPi selects r_rt = 1, r_ch = 1, pulses r_le, then gives 8 r_clk pulses -> r_din bit sequence 1,0,1,0,0,1,0,1; tx_new[1] rises 3 clocks after ti_wr and clears on the r_le event.
- RPi with r_rt = 0, r_ch = 0 shifts 8 bits of 0x3C then pulses r_le -> ti_rdata (ti_rsel = 0, ti_rdir = 0) = 0x3C, rx_new[0] = 1; ti_rack with ti_rsel = 0 -> rx_new[0] = 0.
- RPi write to ch1 with 7 bits, then r_le -> rx_reg[1] keeps its prior value 0x00 and rx_err[1] = 1; a following correct 8-bit write of 0xFF -> rx_err[1] = 0 and rx_new[1] = 1.
- ti_rack pulsed on the same cycle as an rx_new[0] set event -> rx_new[0] = 1 afterwards.
- Assert reset after 4 of 8 r_clk pulses during an RPi write, release, then perform a full 8-bit write of 0x81 -> rx_reg[0] = 0x81 with no rx_err.

Source files
------------

// File: rtl/tipi_sreg_bank_pkg.sv
// -----------------------------------------------------------------------------
// tipi_pkg
// Shared definitions for the TI-99/4A <-> Raspberry Pi serial register bank:
//   RT_WRITE / RT_READ : values of the RPi direction line r_rt
//   link_state_e       : RPi link state (IDLE, SHIFT)
//   clog2()            : constant ceiling-log2 used for parameter checks/widths
// No ports (package).
// -----------------------------------------------------------------------------
package tipi_pkg;

  localparam logic RT_WRITE = 1'b0;  // RPi shifts data in
  localparam logic RT_READ  = 1'b1;  // RPi shifts data out

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } link_state_e;

  function automatic int clog2(input int value);
    int res;
    int v;
    res = 0;
    v   = value - 1;
    while (v > 0) begin
      res++;
      v = v >> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/tipi_sreg_bank_if.sv
// -----------------------------------------------------------------------------
// tipi_sreg_bank_if
// Bundles the TI bus side and the RPi serial link of the register bank.
//   TI  : ti_wr, ti_wsel, ti_wdata (write), ti_rsel, ti_rdir, ti_rdata (read),
//         ti_rack (consume RPi->TI data)
//   RPi : r_clk, r_le, r_rt, r_ch, r_dout (to bank), r_din (from bank)
//   Status : tx_new, rx_new, rx_err (one bit per channel)
// master = bus owner / stimulus side, slave = register bank.
// -----------------------------------------------------------------------------
interface tipi_sreg_bank_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 2,
  parameter int CH_W     = 1
);

  logic                ti_wr;
  logic [CH_W-1:0]     ti_wsel;
  logic [WIDTH-1:0]    ti_wdata;
  logic [CH_W-1:0]     ti_rsel;
  logic                ti_rdir;
  logic [WIDTH-1:0]    ti_rdata;
  logic                ti_rack;

  logic                r_clk;
  logic                r_le;
  logic                r_rt;
  logic [CH_W-1:0]     r_ch;
  logic                r_dout;
  logic                r_din;

  logic [CHANNELS-1:0] tx_new;
  logic [CHANNELS-1:0] rx_new;
  logic [CHANNELS-1:0] rx_err;

  modport master (
    output ti_wr, ti_wsel, ti_wdata, ti_rsel, ti_rdir, ti_rack,
    output r_clk, r_le, r_rt, r_ch, r_dout,
    input  ti_rdata, r_din, tx_new, rx_new, rx_err
  );

  modport slave (
    input  ti_wr, ti_wsel, ti_wdata, ti_rsel, ti_rdir, ti_rack,
    input  r_clk, r_le, r_rt, r_ch, r_dout,
    output ti_rdata, r_din, tx_new, rx_new, rx_err
  );

endinterface

// File: rtl/tipi_sync_edge.sv
// -----------------------------------------------------------------------------
// tipi_sync_edge
// Multi-flop synchroniser with rising-edge detect.
//   clk     : system clock
//   reset   : synchronous active-high reset (chain cleared -> no edge after reset)
//   async_i : asynchronous input
//   sync_o  : synchronised level
//   rise_o  : one-cycle pulse on a synchronised 0->1 transition
// -----------------------------------------------------------------------------
module tipi_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic async_i,
  output logic sync_o,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] chain_q;
  logic [SYNC_STAGES-1:0] chain_d;
  logic                   prev_q;

  assign chain_d = {chain_q[SYNC_STAGES-2:0], async_i};

  always_ff @(posedge clk) begin
    if (reset) begin
      chain_q <= '0;
      prev_q  <= 1'b0;
    end else begin
      chain_q <= chain_d;
      prev_q  <= chain_q[SYNC_STAGES-1];
    end
  end

  assign sync_o = chain_q[SYNC_STAGES-1];
  assign rise_o = sync_o & ~prev_q;

endmodule

// File: rtl/tipi_sreg_bank.sv
// -----------------------------------------------------------------------------
// tipi_sreg_bank
// CHANNELS pairs of WIDTH-bit registers between the TI-99/4A bus and the RPi
// serial link. Each pair: tx_reg (TI->RPi) and rx_reg (RPi->TI).
//   clk, reset : system clock, synchronous active-high reset
//   bus        : tipi_sreg_bank_if.slave (TI bus, RPi link, status flags)
// All async strobes (ti_wr, r_clk, r_le) are synchronised; r_rt/r_ch/r_dout
// are quasi-static (RPi changes them on the falling r_clk edge) and sampled
// directly when the synchronised events fire.
//
// Link states:
//   state | meaning
//   IDLE  | no transfer in progress; next r_clk event starts one
//   SHIFT | shifting; r_rt/r_ch captured at the first r_clk event
// -----------------------------------------------------------------------------
module tipi_sreg_bank
  import tipi_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int CHANNELS    = 2,
  parameter int CH_W        = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  tipi_sreg_bank_if.slave  bus
);

  localparam int CNT_W = clog2(WIDTH + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(WIDTH + 1);

  generate
    if (CH_W != ((CHANNELS > 1) ? clog2(CHANNELS) : 1)) begin : g_bad_ch_w
      $error("tipi_sreg_bank: CH_W must equal clog2(CHANNELS), minimum 1");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("tipi_sreg_bank: SYNC_STAGES must be at least 2");
    end
  endgenerate

  logic wr_lvl, wr_ev;
  logic rclk_lvl, rclk_ev;
  logic rle_lvl, rle_ev;

  tipi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_wr (
    .clk(clk), .reset(reset), .async_i(bus.ti_wr), .sync_o(wr_lvl), .rise_o(wr_ev)
  );
  tipi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_rclk (
    .clk(clk), .reset(reset), .async_i(bus.r_clk), .sync_o(rclk_lvl), .rise_o(rclk_ev)
  );
  tipi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_rle (
    .clk(clk), .reset(reset), .async_i(bus.r_le), .sync_o(rle_lvl), .rise_o(rle_ev)
  );

  // Only the edges drive the bank; the levels are kept for observability.
  logic unused_levels;
  assign unused_levels = ^{wr_lvl, rclk_lvl, rle_lvl};

  logic [WIDTH-1:0]    tx_reg_q [CHANNELS];
  logic [WIDTH-1:0]    rx_reg_q [CHANNELS];
  logic [WIDTH-1:0]    shift_in_q;
  logic [WIDTH-1:0]    shift_out_q;
  logic [CNT_W-1:0]    bitcnt_q;
  logic [CNT_W-1:0]    bitcnt_d;
  logic                r_din_q;
  logic [CHANNELS-1:0] tx_new_q;
  logic [CHANNELS-1:0] rx_new_q;
  logic [CHANNELS-1:0] rx_err_q;
  link_state_e         link_q;
  logic                rt_q;
  logic [CH_W-1:0]     ch_q;
  logic                sel_change;

  assign sel_change = (bus.r_rt != rt_q) || (bus.r_ch != ch_q);

  // A select change seen together with an r_clk event starts a fresh
  // transfer, so that bit counts as the first one.
  always_comb begin
    bitcnt_d = bitcnt_q;
    if ((link_q == SHIFT) && sel_change)
      bitcnt_d = CNT_W'(1);
    else if (bitcnt_q != CNT_SAT)
      bitcnt_d = bitcnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        tx_reg_q[i] <= '0;
        rx_reg_q[i] <= '0;
      end
      shift_in_q  <= '0;
      shift_out_q <= '0;
      bitcnt_q    <= '0;
      r_din_q     <= 1'b0;
      tx_new_q    <= '0;
      rx_new_q    <= '0;
      rx_err_q    <= '0;
      link_q      <= IDLE;
      rt_q        <= RT_WRITE;
      ch_q        <= '0;
    end else begin
      // Ack first so a same-cycle rx_new set below takes priority.
      if (bus.ti_rack)
        rx_new_q[bus.ti_rsel] <= 1'b0;

      // r_le has priority; a coincident r_clk event is dropped.
      if (rle_ev) begin
        link_q   <= IDLE;
        bitcnt_q <= '0;
        if (bus.r_rt == RT_READ) begin
          shift_out_q           <= tx_reg_q[bus.r_ch];
          r_din_q               <= tx_reg_q[bus.r_ch][WIDTH-1];
          tx_new_q[bus.r_ch]    <= 1'b0;
        end else if (bitcnt_q == CNT_FULL) begin
          rx_reg_q[bus.r_ch]    <= shift_in_q;
          rx_new_q[bus.r_ch]    <= 1'b1;
          rx_err_q[bus.r_ch]    <= 1'b0;
        end else begin
          rx_err_q[bus.r_ch]    <= 1'b1;
        end
      end else if (rclk_ev) begin
        link_q <= SHIFT;
        rt_q   <= bus.r_rt;
        ch_q   <= bus.r_ch;
        if (bus.r_rt == RT_READ) begin
          shift_out_q <= {shift_out_q[WIDTH-2:0], 1'b0};
          r_din_q     <= shift_out_q[WIDTH-2];
        end else begin
          shift_in_q  <= {shift_in_q[WIDTH-2:0], bus.r_dout};
          bitcnt_q    <= bitcnt_d;
        end
      end else if ((link_q == SHIFT) && sel_change) begin
        // Direction/channel changed mid-transfer: abandon it.
        link_q   <= IDLE;
        bitcnt_q <= '0;
      end

      // Placed last so a TI write beats a same-cycle RPi fetch clearing tx_new.
      if (wr_ev) begin
        tx_reg_q[bus.ti_wsel] <= bus.ti_wdata;
        tx_new_q[bus.ti_wsel] <= 1'b1;
      end
    end
  end

  always_comb begin
    bus.ti_rdata = bus.ti_rdir ? tx_reg_q[bus.ti_rsel] : rx_reg_q[bus.ti_rsel];
  end

  assign bus.r_din  = r_din_q;
  assign bus.tx_new = tx_new_q;
  assign bus.rx_new = rx_new_q;
  assign bus.rx_err = rx_err_q;

endmodule

// File: tb/tb_tipi_sreg_bank.sv
module tb_tipi_sreg_bank;

  localparam int WIDTH       = 8;
  localparam int CHANNELS    = 2;
  localparam int CH_W        = 1;
  localparam int SYNC_STAGES = 2;

  logic clk;
  logic reset;

  tipi_sreg_bank_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .CH_W(CH_W)) bus ();

  tipi_sreg_bank #(
    .WIDTH(WIDTH), .CHANNELS(CHANNELS), .CH_W(CH_W), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [CH_W-1:0] ch;
    logic [15:0]     data;
    int              nbits;
    bit              ack;
    logic [7:0]      exp_rdata;
    bit              exp_new;
    bit              exp_err;
  } wr_vec_t;

  wr_vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_rclk();
    bus.r_clk = 1'b1;
    tick(4);
    bus.r_clk = 1'b0;
    tick(4);
  endtask

  task automatic pulse_rle();
    bus.r_le = 1'b1;
    tick(4);
    bus.r_le = 1'b0;
    tick(4);
  endtask

  task automatic shift_bits(input logic [15:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      bus.r_dout = d[n-1-i];
      pulse_rclk();
    end
  endtask

  task automatic read_rx(input logic [CH_W-1:0] ch, input logic dir);
    bus.ti_rsel = ch;
    bus.ti_rdir = dir;
    #1;
  endtask

  logic [7:0] pat;

  initial begin
    vecs[0] = '{ch: 1'b0, data: 16'h003C, nbits: 8,  ack: 1'b1, exp_rdata: 8'h3C, exp_new: 1'b1, exp_err: 1'b0};
    vecs[1] = '{ch: 1'b1, data: 16'h007F, nbits: 7,  ack: 1'b0, exp_rdata: 8'h00, exp_new: 1'b0, exp_err: 1'b1};
    vecs[2] = '{ch: 1'b1, data: 16'h00FF, nbits: 8,  ack: 1'b0, exp_rdata: 8'hFF, exp_new: 1'b1, exp_err: 1'b0};
    vecs[3] = '{ch: 1'b0, data: 16'h05A5, nbits: 12, ack: 1'b0, exp_rdata: 8'h3C, exp_new: 1'b0, exp_err: 1'b1};
    vecs[4] = '{ch: 1'b0, data: 16'h0096, nbits: 8,  ack: 1'b1, exp_rdata: 8'h96, exp_new: 1'b1, exp_err: 1'b0};

    reset = 1'b1;
    bus.ti_wr = 1'b0; bus.ti_wsel = '0; bus.ti_wdata = '0;
    bus.ti_rsel = '0; bus.ti_rdir = 1'b0; bus.ti_rack = 1'b0;
    bus.r_clk = 1'b0; bus.r_le = 1'b0; bus.r_rt = 1'b0; bus.r_ch = '0; bus.r_dout = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(10);

    // Reset state
    check("reset_tx_new", 32'(bus.tx_new), 32'h0);
    check("reset_rx_new", 32'(bus.rx_new), 32'h0);
    check("reset_rx_err", 32'(bus.rx_err), 32'h0);
    check("reset_r_din",  32'(bus.r_din),  32'h0);
    for (int c = 0; c < CHANNELS; c++) begin
      for (int d = 0; d < 2; d++) begin
        read_rx(CH_W'(c), d[0]);
        check($sformatf("reset_rdata_ch%0d_dir%0d", c, d), 32'(bus.ti_rdata), 32'h0);
      end
    end

    // TI write 0xA5 to ch1, tx_new latency
    bus.ti_wsel = 1'b1;
    bus.ti_wdata = 8'hA5;
    bus.ti_wr = 1'b1;
    tick(2);
    check("tx_new_before_latency", 32'(bus.tx_new[1]), 32'h0);
    tick(1);
    check("tx_new_at_latency", 32'(bus.tx_new[1]), 32'h1);
    tick(2);
    bus.ti_wr = 1'b0;
    tick(4);
    read_rx(1'b1, 1'b1);
    check("tx_readback_ch1", 32'(bus.ti_rdata), 32'hA5);

    // RPi fetch of ch1
    bus.r_rt = 1'b1;
    bus.r_ch = 1'b1;
    pulse_rle();
    check("fetch_tx_new_cleared", 32'(bus.tx_new[1]), 32'h0);
    pat = 8'hA5;
    check("fetch_bit7", 32'(bus.r_din), 32'(pat[7]));
    for (int k = 1; k < 8; k++) begin
      pulse_rclk();
      check($sformatf("fetch_bit%0d", 7 - k), 32'(bus.r_din), 32'(pat[7-k]));
    end
    pulse_rclk();
    check("fetch_drained", 32'(bus.r_din), 32'h0);

    // RPi write vectors
    bus.r_rt = 1'b0;
    for (int v = 0; v < 5; v++) begin
      bus.r_ch = vecs[v].ch;
      shift_bits(vecs[v].data, vecs[v].nbits);
      pulse_rle();
      read_rx(vecs[v].ch, 1'b0);
      check($sformatf("vec%0d_rdata", v), 32'(bus.ti_rdata), 32'(vecs[v].exp_rdata));
      check($sformatf("vec%0d_rx_new", v), 32'(bus.rx_new[vecs[v].ch]), 32'(vecs[v].exp_new));
      check($sformatf("vec%0d_rx_err", v), 32'(bus.rx_err[vecs[v].ch]), 32'(vecs[v].exp_err));
      if (vecs[v].ack) begin
        bus.ti_rsel = vecs[v].ch;
        bus.ti_rack = 1'b1;
        tick(1);
        bus.ti_rack = 1'b0;
        tick(1);
        check($sformatf("vec%0d_ack_clears", v), 32'(bus.rx_new[vecs[v].ch]), 32'h0);
      end
    end

    // ti_rack in the same cycle as the rx_new set: set wins
    bus.r_ch = 1'b0;
    shift_bits(16'h0042, 8);
    bus.r_le = 1'b1;
    tick(2);
    bus.ti_rsel = 1'b0;
    bus.ti_rack = 1'b1;
    tick(1);
    bus.ti_rack = 1'b0;
    tick(1);
    bus.r_le = 1'b0;
    tick(4);
    check("ack_vs_set_rx_new", 32'(bus.rx_new[0]), 32'h1);
    read_rx(1'b0, 1'b0);
    check("ack_vs_set_rdata", 32'(bus.ti_rdata), 32'h42);

    // Reset mid-transfer, then a clean write of 0x81
    shift_bits(16'h0008, 4);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(2);
    read_rx(1'b0, 1'b0);
    check("midreset_rdata", 32'(bus.ti_rdata), 32'h0);
    check("midreset_rx_new", 32'(bus.rx_new), 32'h0);
    check("midreset_rx_err", 32'(bus.rx_err), 32'h0);
    shift_bits(16'h0081, 8);
    pulse_rle();
    read_rx(1'b0, 1'b0);
    check("post_reset_rdata", 32'(bus.ti_rdata), 32'h81);
    check("post_reset_rx_err", 32'(bus.rx_err[0]), 32'h0);
    check("post_reset_rx_new", 32'(bus.rx_new[0]), 32'h1);

    // TI write and RPi fetch of the same channel in the same cycle
    bus.ti_wsel = 1'b0;
    bus.ti_wdata = 8'h91;
    bus.ti_wr = 1'b1;
    tick(4);
    bus.ti_wr = 1'b0;
    tick(4);
    bus.r_rt = 1'b1;
    bus.r_ch = 1'b0;
    tick(2);
    bus.ti_wdata = 8'h22;
    bus.ti_wr = 1'b1;
    bus.r_le = 1'b1;
    tick(4);
    bus.ti_wr = 1'b0;
    bus.r_le = 1'b0;
    tick(4);
    check("collide_r_din_old_msb", 32'(bus.r_din), 32'h1);
    check("collide_tx_new", 32'(bus.tx_new[0]), 32'h1);
    read_rx(1'b0, 1'b1);
    check("collide_tx_reg_new", 32'(bus.ti_rdata), 32'h22);
    pulse_rclk();
    pulse_rclk();
    pulse_rclk();
    check("collide_old_bit4", 32'(bus.r_din), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
